// File: rtl/dance_step_sequencer_if.sv
// Signal bundle between the step sequencer, its pattern ROM and the four-lane scorer.
interface dance_step_sequencer_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic              pause;
  logic [ADDR_W-1:0] pat_addr;
  logic [4:0]        pat_data;
  logic [3:0]        enable_count;
  logic              score_clr;
  logic [1:0]        countdown;
  logic [ADDR_W-1:0] step_index;
  logic              busy;
  logic              song_done;

  modport master (
    input  start, pause, pat_data,
    output pat_addr, enable_count, score_clr, countdown, step_index, busy, song_done
  );

  modport slave (
    output start, pause, pat_data,
    input  pat_addr, enable_count, score_clr, countdown, step_index, busy, song_done
  );
endinterface

// File: rtl/dance_step_sequencer.sv
// Tempo-driven step sequencer: 3-beat count-in, then one lane-mask cue per beat from a
// synchronous pattern ROM until an end marker or the last address.
module dance_step_sequencer #(
  parameter int BEAT_CYCLES = 25000000,
  parameter int ADDR_W      = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  dance_step_sequencer_if.master io_bus
);

  localparam int                CNT_W     = $clog2(BEAT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  FETCH_CNT = CNT_W'(BEAT_CYCLES - 3);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREROLL,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic [1:0]        r_countdown;
  logic [ADDR_W-1:0] r_pat_addr;
  logic [ADDR_W-1:0] r_step_index;
  logic [3:0]        r_mask;
  logic              r_last;
  logic              r_score_clr;
  logic              w_run;
  logic              w_accept;
  logic              w_busy;
  logic              w_done;
  logic [3:0]        w_enable;

  assign w_run = ~io_bus.pause;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FETCH, LOAD and ISSUE each take one beat-counter tick, so WAIT hands over to FETCH
  // three ticks before the beat ends and cues stay exactly one beat apart.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_enable = 4'd0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_done = (r_state == S_DONE);
        if (io_bus.start) begin
          w_accept = 1'b1;
          w_next   = S_PREROLL;
        end
      end
      S_PREROLL: begin
        w_busy = 1'b1;
        if (w_run && r_countdown == 2'd1 && r_beat_cnt == FETCH_CNT) begin
          w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        w_busy = 1'b1;
        if (w_run) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_busy = 1'b1;
        if (w_run) begin
          w_next = (io_bus.pat_data[4] || r_last) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_busy = 1'b1;
        if (w_run) begin
          w_enable = r_mask;
          w_next   = S_WAIT;
        end
      end
      S_WAIT: begin
        w_busy = 1'b1;
        if (w_run && r_beat_cnt == FETCH_CNT) begin
          w_next = S_FETCH;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat_cnt   <= '0;
      r_countdown  <= 2'd0;
      r_pat_addr   <= '0;
      r_step_index <= '0;
      r_mask       <= 4'd0;
      r_last       <= 1'b0;
      r_score_clr  <= 1'b0;
    end else begin
      r_score_clr <= w_accept;
      if (w_accept) begin
        r_beat_cnt   <= '0;
        r_countdown  <= 2'd3;
        r_pat_addr   <= '0;
        r_step_index <= '0;
        r_mask       <= 4'd0;
        r_last       <= 1'b0;
      end else if (w_busy && w_run) begin
        r_beat_cnt <= (r_beat_cnt == LAST_CNT) ? '0 : r_beat_cnt + CNT_W'(1);
        if (r_beat_cnt == LAST_CNT && r_countdown != 2'd0) begin
          r_countdown <= r_countdown - 2'd1;
        end
        if (r_state == S_LOAD && w_next == S_ISSUE) begin
          r_mask       <= io_bus.pat_data[3:0];
          r_step_index <= r_pat_addr;
        end
        // The final address is never advanced past, so the ROM never sees address 0 mid-song.
        if (r_state == S_ISSUE) begin
          if (r_pat_addr == LAST_ADDR) begin
            r_last <= 1'b1;
          end else begin
            r_pat_addr <= r_pat_addr + ADDR_W'(1);
          end
        end
      end
    end
  end

  assign io_bus.pat_addr     = r_pat_addr;
  assign io_bus.enable_count = w_enable;
  assign io_bus.score_clr    = r_score_clr;
  assign io_bus.countdown    = r_countdown;
  assign io_bus.step_index   = r_step_index;
  assign io_bus.busy         = w_busy;
  assign io_bus.song_done    = w_done;

endmodule

// File: tb/tb_dance_step_sequencer.sv
// Bench for dance_step_sequencer: per-cycle traces compared against a beat-time model
// built from elapsed unpaused cycles, plus fixed-timing scenario checks.
module tb_dance_step_sequencer;

  localparam int B     = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int MAXC  = 240;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  dance_step_sequencer_if #(.ADDR_W(AW)) bus ();

  dance_step_sequencer #(.BEAT_CYCLES(B), .ADDR_W(AW)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  logic [4:0] rom [DEPTH];
  always @(posedge clk) bus.pat_data <= rom[bus.pat_addr];

  bit          st_in   [MAXC];
  bit          pz_in   [MAXC];
  bit          rs_in   [MAXC];
  logic [8:0]  obs_vec [MAXC];
  logic [8:0]  exp_vec [MAXC];
  logic [AW-1:0] obs_idx  [MAXC];
  logic [AW-1:0] obs_addr [MAXC];
  bit          exp_cue [MAXC];
  int          exp_k   [MAXC];

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      st_in[i] = 1'b0;
      pz_in[i] = 1'b0;
      rs_in[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Cue k is due once 3 beats plus k beats of unpaused time have elapsed since start.
  task automatic build_expect(input int n);
    bit active = 1'b0;
    bit done = 1'b0;
    int e = 0;
    int k;
    logic [3:0] en;
    logic [1:0] cd;
    bit clr;
    for (int c = 0; c < n; c++) begin
      exp_cue[c] = 1'b0;
      exp_k[c] = 0;
      en = 4'd0;
      cd = 2'd0;
      clr = 1'b0;
      if (c > 0 && rs_in[c-1]) begin
        active = 1'b0;
        done = 1'b0;
      end else if (c > 0 && st_in[c-1] && (!active || done)) begin
        active = 1'b1;
        done = 1'b0;
        e = 0;
        clr = 1'b1;
      end
      if (active && !done) begin
        if (e >= 3*B && (e - 3*B) % B == 0) begin
          k = (e - 3*B) / B;
          if (k >= DEPTH || rom[k][4]) begin
            done = 1'b1;
          end else begin
            exp_cue[c] = 1'b1;
            exp_k[c] = k;
            if (!pz_in[c]) en = rom[k][3:0];
          end
        end
        if (!done) begin
          if (e < 3*B) cd = 2'(3 - e / B);
          if (!pz_in[c]) e++;
        end
      end
      exp_vec[c] = {en, clr, cd, active && !done, done};
    end
  endtask

  task automatic run_song(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      reset = rs_in[c];
      bus.start = st_in[c];
      bus.pause = pz_in[c];
      @(negedge clk);
      obs_vec[c]  = {bus.enable_count, bus.score_clr, bus.countdown, bus.busy, bus.song_done};
      obs_idx[c]  = bus.step_index;
      obs_addr[c] = bus.pat_addr;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
  endtask

  task automatic test_reset();
    int n = 110;
    rom = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h00, 5'h00, 5'h00};
    clear_stim();
    st_in[2] = 1'b1;
    rs_in[30] = 1'b1;
    st_in[40] = 1'b1;
    do_reset();
    build_expect(n);
    run_song(n);
    tests++;
    if (obs_vec[0] !== 9'h000 || obs_addr[0] !== '0 || obs_idx[0] !== '0) begin
      fails++;
      $display("[TB] FAIL reset_state: got vec=%h addr=%0d idx=%0d, expected all 0", obs_vec[0], obs_addr[0], obs_idx[0]);
    end
    tests++;
    if (obs_vec[31] !== 9'h000 || obs_addr[31] !== '0 || obs_idx[31] !== '0) begin
      fails++;
      $display("[TB] FAIL reset_mid_song: got vec=%h addr=%0d idx=%0d, expected all 0", obs_vec[31], obs_addr[31], obs_idx[31]);
    end
    tests++;
    if (obs_vec[41][4] !== 1'b1 || obs_vec[65][8:5] !== 4'h1) begin
      fails++;
      $display("[TB] FAIL reset_replay: got clr@41=%b en@65=%h, expected 1 and 1", obs_vec[41][4], obs_vec[65][8:5]);
    end
    for (int c = 0; c < n; c++) begin
      tests++;
      if (obs_vec[c] !== exp_vec[c]) begin
        fails++;
        $display("[TB] FAIL reset_trace cycle %0d: got %h, expected %h", c, obs_vec[c], exp_vec[c]);
      end
      if (exp_cue[c]) begin
        tests++;
        if (obs_idx[c] !== AW'(exp_k[c])) begin
          fails++;
          $display("[TB] FAIL reset_index cycle %0d: got %0d, expected %0d", c, obs_idx[c], exp_k[c]);
        end
      end
    end
  endtask

  task automatic test_basic_song();
    int n = 80;
    int pulses = 0;
    rom = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h00, 5'h00, 5'h00};
    clear_stim();
    st_in[10] = 1'b1;
    do_reset();
    build_expect(n);
    run_song(n);
    tests++;
    if (obs_vec[11][4] !== 1'b1 || obs_vec[12][4] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_score_clr: got %b%b at 11/12, expected 10", obs_vec[11][4], obs_vec[12][4]);
    end
    tests++;
    if (obs_vec[18][3:2] !== 2'd3 || obs_vec[19][3:2] !== 2'd2 || obs_vec[34][3:2] !== 2'd1 || obs_vec[35][3:2] !== 2'd0) begin
      fails++;
      $display("[TB] FAIL basic_countdown: got %0d %0d %0d %0d, expected 3 2 1 0", obs_vec[18][3:2], obs_vec[19][3:2], obs_vec[34][3:2], obs_vec[35][3:2]);
    end
    tests++;
    if (obs_vec[35][8:5] !== 4'h1 || obs_vec[43][8:5] !== 4'h2 || obs_vec[51][8:5] !== 4'h4 || obs_vec[59][8:5] !== 4'h8) begin
      fails++;
      $display("[TB] FAIL basic_cues: got %h %h %h %h, expected 1 2 4 8", obs_vec[35][8:5], obs_vec[43][8:5], obs_vec[51][8:5], obs_vec[59][8:5]);
    end
    for (int c = 0; c < n; c++) if (obs_vec[c][8:5] != 4'h0) pulses++;
    tests++;
    if (pulses !== 4 || obs_vec[67][0] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL basic_end: got pulses=%0d done@67=%b, expected 4 and 1", pulses, obs_vec[67][0]);
    end
    for (int c = 0; c < n; c++) begin
      tests++;
      if (obs_vec[c] !== exp_vec[c]) begin
        fails++;
        $display("[TB] FAIL basic_trace cycle %0d: got %h, expected %h", c, obs_vec[c], exp_vec[c]);
      end
      if (exp_cue[c]) begin
        tests++;
        if (obs_idx[c] !== AW'(exp_k[c])) begin
          fails++;
          $display("[TB] FAIL basic_index cycle %0d: got %0d, expected %0d", c, obs_idx[c], exp_k[c]);
        end
      end
    end
  endtask

  task automatic test_rest_chord();
    int n = 60;
    rom = '{5'h00, 5'h0F, 5'h10, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00};
    clear_stim();
    st_in[10] = 1'b1;
    do_reset();
    build_expect(n);
    run_song(n);
    tests++;
    if (obs_vec[35][8:5] !== 4'h0 || obs_vec[43][8:5] !== 4'hF || obs_vec[44][8:5] !== 4'h0 || obs_vec[51][0] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL rest_chord: got en35=%h en43=%h en44=%h done51=%b, expected 0 F 0 1", obs_vec[35][8:5], obs_vec[43][8:5], obs_vec[44][8:5], obs_vec[51][0]);
    end
    for (int c = 0; c < n; c++) begin
      tests++;
      if (obs_vec[c] !== exp_vec[c]) begin
        fails++;
        $display("[TB] FAIL rest_trace cycle %0d: got %h, expected %h", c, obs_vec[c], exp_vec[c]);
      end
    end
  endtask

  task automatic test_pause();
    int n = 85;
    rom = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h00, 5'h00, 5'h00};
    clear_stim();
    st_in[10] = 1'b1;
    for (int c = 40; c < 45; c++) pz_in[c] = 1'b1;
    do_reset();
    build_expect(n);
    run_song(n);
    tests++;
    if (obs_vec[43][8:5] !== 4'h0 || obs_vec[48][8:5] !== 4'h2 || obs_vec[56][8:5] !== 4'h4 || obs_vec[64][8:5] !== 4'h8 || obs_vec[72][0] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL pause_shift: got en43=%h en48=%h en56=%h en64=%h done72=%b, expected 0 2 4 8 1", obs_vec[43][8:5], obs_vec[48][8:5], obs_vec[56][8:5], obs_vec[64][8:5], obs_vec[72][0]);
    end
    for (int c = 0; c < n; c++) begin
      tests++;
      if (obs_vec[c] !== exp_vec[c]) begin
        fails++;
        $display("[TB] FAIL pause_trace cycle %0d: got %h, expected %h", c, obs_vec[c], exp_vec[c]);
      end
    end
  endtask

  task automatic test_wrap();
    int n = 110;
    int cues = 0;
    rom = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h03, 5'h05, 5'h0A, 5'h0C};
    clear_stim();
    st_in[10] = 1'b1;
    do_reset();
    build_expect(n);
    run_song(n);
    for (int c = 0; c < n; c++) if (obs_vec[c][8:5] != 4'h0) cues++;
    tests++;
    if (cues !== 8 || obs_vec[99][0] !== 1'b1 || obs_vec[98][0] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL wrap_end: got cues=%0d done98=%b done99=%b, expected 8 0 1", cues, obs_vec[98][0], obs_vec[99][0]);
    end
    for (int c = 36; c < n; c++) begin
      tests++;
      if (obs_addr[c] === '0) begin
        fails++;
        $display("[TB] FAIL wrap_addr cycle %0d: got %0d, expected nonzero", c, obs_addr[c]);
      end
    end
    for (int c = 0; c < n; c++) begin
      tests++;
      if (obs_vec[c] !== exp_vec[c]) begin
        fails++;
        $display("[TB] FAIL wrap_trace cycle %0d: got %h, expected %h", c, obs_vec[c], exp_vec[c]);
      end
      if (exp_cue[c]) begin
        tests++;
        if (obs_idx[c] !== AW'(exp_k[c])) begin
          fails++;
          $display("[TB] FAIL wrap_index cycle %0d: got %0d, expected %0d", c, obs_idx[c], exp_k[c]);
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    int n = 75;
    int clrs = 0;
    rom = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h00, 5'h00, 5'h00};
    clear_stim();
    st_in[10] = 1'b1;
    st_in[38] = 1'b1;
    do_reset();
    build_expect(n);
    run_song(n);
    for (int c = 0; c < n; c++) if (obs_vec[c][4]) clrs++;
    tests++;
    if (clrs !== 1 || obs_vec[43][8:5] !== 4'h2) begin
      fails++;
      $display("[TB] FAIL busy_start: got clr_count=%0d en43=%h, expected 1 and 2", clrs, obs_vec[43][8:5]);
    end
    for (int c = 0; c < n; c++) begin
      tests++;
      if (obs_vec[c] !== exp_vec[c]) begin
        fails++;
        $display("[TB] FAIL busy_trace cycle %0d: got %h, expected %h", c, obs_vec[c], exp_vec[c]);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        rom[i] = {($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15))};
      end
      clear_stim();
      st_in[$urandom_range(1, 6)] = 1'b1;
      st_in[$urandom_range(60, 200)] = 1'b1;
      for (int c = 0; c < MAXC; c++) pz_in[c] = ($urandom_range(0, 6) == 0);
      do_reset();
      build_expect(MAXC);
      run_song(MAXC);
      for (int c = 0; c < MAXC; c++) begin
        tests++;
        if (obs_vec[c] !== exp_vec[c]) begin
          fails++;
          $display("[TB] FAIL random%0d_trace cycle %0d: got %h, expected %h", r, c, obs_vec[c], exp_vec[c]);
        end
        if (exp_cue[c]) begin
          tests++;
          if (obs_idx[c] !== AW'(exp_k[c])) begin
            fails++;
            $display("[TB] FAIL random%0d_index cycle %0d: got %0d, expected %0d", r, c, obs_idx[c], exp_k[c]);
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = 5'h00;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    test_reset();
    test_basic_song();
    test_rest_chord();
    test_pause();
    test_wrap();
    test_start_while_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
